// File: rtl/aes128_core_arbiter_if.sv
// Bus bundle between requesters, the shared AES-128 core and the response consumer.
// master: requester/consumer/core side, slave: aes128_core_arbiter.
interface aes128_core_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*128-1:0] req_ptext;
    logic [NUM_REQ*128-1:0] req_key;
    logic [127:0]           core_ptext;
    logic [127:0]           core_key;
    logic [127:0]           core_ctext;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [127:0]           resp_ctext;
    logic [ID_W-1:0]        resp_id;

    modport master (
        output req_valid, req_ptext, req_key, core_ctext, resp_ready,
        input  req_ready, core_ptext, core_key, resp_valid, resp_ctext, resp_id
    );

    modport slave (
        input  req_valid, req_ptext, req_key, core_ctext, resp_ready,
        output req_ready, core_ptext, core_key, resp_valid, resp_ctext, resp_id
    );
endinterface

// File: rtl/aes128_core_arbiter.sv
// Round-robin sequencer sharing one combinational AES-128 core among NUM_REQ requesters.
// Define AES_ARB_ZEROIZE_EN to clear core inputs and response data once they are consumed.
module aes128_core_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned CORE_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes128_core_arbiter_if.slave bus,
    output logic                 busy
);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
    localparam int unsigned DW    = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   cur_id;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_found;
    logic [CNT_W-1:0]  cnt;
    int unsigned       scan_idx;
    logic [DW-1:0]     ptext_arr [NUM_REQ];
    logic [DW-1:0]     key_arr   [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign ptext_arr[g] = bus.req_ptext[DW*g +: DW];
        assign key_arr[g]   = bus.req_key[DW*g +: DW];
    end

    // First valid requester found scanning upward from just past the previous winner
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            scan_idx = (32'(last_grant) + k) % NUM_REQ;
            if (!grant_found && bus.req_valid[ID_W'(scan_idx)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(scan_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        bus.req_ready = '0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    bus.req_ready = NUM_REQ'(1) << grant_idx;
                    state_next    = RUN;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand latch, settling counter, result capture and response hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy           <= 1'b0;
            last_grant     <= ID_W'(NUM_REQ - 1);
            cur_id         <= '0;
            cnt            <= '0;
            bus.core_ptext <= '0;
            bus.core_key   <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_ctext <= '0;
            bus.resp_id    <= '0;
        end else begin
            busy <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        bus.core_ptext <= ptext_arr[grant_idx];
                        bus.core_key   <= key_arr[grant_idx];
                        cur_id         <= grant_idx;
                        last_grant     <= grant_idx;
                        cnt            <= CNT_W'(CORE_LAT - 1);
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        bus.resp_ctext <= bus.core_ctext;
                        bus.resp_id    <= cur_id;
                        bus.resp_valid <= 1'b1;
`ifdef AES_ARB_ZEROIZE_EN
                        bus.core_ptext <= '0;
                        bus.core_key   <= '0;
`endif
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
`ifdef AES_ARB_ZEROIZE_EN
                        bus.resp_ctext <= '0;
                        bus.resp_id    <= '0;
`else
                        bus.resp_ctext <= bus.resp_ctext;
                        bus.resp_id    <= bus.resp_id;
`endif
                    end
                end
                default: begin
                    bus.resp_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes128_core_arbiter.sv
// Self-checking bench for aes128_core_arbiter; the AES core is stood in for by a lookup model.
module tb_aes128_core_arbiter;
    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned CORE_LAT = 2;
    localparam int unsigned ID_W     = $clog2(NUM_REQ);

    localparam logic [127:0] FIPS_P = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_C = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] ZERO_C = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
`ifdef AES_ARB_ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
`else
    localparam bit ZEROIZE = 1'b0;
`endif

    typedef struct {
        int           port;
        logic [127:0] ptext;
        logic [127:0] key;
        logic [127:0] ctext;
        int           id;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         busy;
    int           cyc = 0;
    int           n_tests = 0;
    int           n_fail = 0;
    logic [127:0] rp [NUM_REQ];
    logic [127:0] rk [NUM_REQ];

    aes128_core_arbiter_if #(.NUM_REQ(NUM_REQ)) bus_if ();

    aes128_core_arbiter #(.NUM_REQ(NUM_REQ), .CORE_LAT(CORE_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
        assign bus_if.req_ptext[128*g +: 128] = rp[g];
        assign bus_if.req_key[128*g +: 128]   = rk[g];
    end

    // Stand-in for the combinational core: known vectors by lookup, anything else a keyed mix
    function automatic logic [127:0] core_fn(input logic [127:0] p, input logic [127:0] k);
        if (p == FIPS_P && k == FIPS_K) return FIPS_C;
        if (p == '0 && k == '0) return ZERO_C;
        return p ^ {k[63:0], k[127:64]} ^ 128'hc3a5_5a3c_0f1e_e1f0_9669_6996_a55a_3cc3;
    endfunction

    assign bus_if.core_ctext = core_fn(bus_if.core_ptext, bus_if.core_key);

    function automatic logic [NUM_REQ-1:0] onehot(input int i);
        return NUM_REQ'(1) << i;
    endfunction

    function automatic int rr_pick(input logic [NUM_REQ-1:0] m, input int last);
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            int c;
            c = (last + k) % int'(NUM_REQ);
            if (((m >> c) & NUM_REQ'(1)) != '0) return c;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock; grant invariants are sampled at the falling edge on the way
    task automatic tick();
        @(negedge clk);
        check("req_ready_onehot0", 128'($onehot0(bus_if.req_ready)), 128'(1));
        check("req_ready_while_busy", 128'(busy && (bus_if.req_ready != '0)), 128'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ports();
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            rp[ID_W'(i)] = {$urandom, $urandom, $urandom, $urandom};
            rk[ID_W'(i)] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic check_reset_vals();
        check("rst_resp_valid", 128'(bus_if.resp_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_req_ready", 128'(bus_if.req_ready), 128'(0));
        check("rst_core_ptext", bus_if.core_ptext, 128'(0));
        check("rst_core_key", bus_if.core_key, 128'(0));
        check("rst_resp_ctext", bus_if.resp_ctext, 128'(0));
        check("rst_resp_id", 128'(bus_if.resp_id), 128'(0));
    endtask

    task automatic do_reset();
        bus_if.req_valid = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Present mask, wait (bounded) for a grant, check it, and step past the accept edge
    task automatic wait_accept(input logic [NUM_REQ-1:0] mask, input int exp_id, output int acc);
        int n;
        n = 0;
        bus_if.req_valid = mask;
        #1;
        while (bus_if.req_ready == '0 && n < 40) begin
            tick();
            #1;
            n++;
        end
        check("grant", 128'(bus_if.req_ready), 128'(onehot(exp_id)));
        acc = cyc + 1;
        tick();
    endtask

    // Follow one operation from the cycle after accept through the response handshake
    task automatic wait_resp(input int exp_id, input logic [127:0] p, input logic [127:0] k,
                             input logic [127:0] c, input int acc, input int hold);
        int n;
        n = 0;
        bus_if.resp_ready = (hold == 0);
        check("run_core_ptext", bus_if.core_ptext, p);
        check("run_core_key", bus_if.core_key, k);
        check("run_busy", 128'(busy), 128'(1));
        while (!bus_if.resp_valid && n < 40) begin
            tick();
            n++;
        end
        check("latency", 128'(cyc - acc), 128'(CORE_LAT));
        check("resp_id", 128'(bus_if.resp_id), 128'(exp_id));
        check("resp_ctext", bus_if.resp_ctext, c);
        check("resp_core_key", bus_if.core_key, ZEROIZE ? '0 : k);
        check("resp_core_ptext", bus_if.core_ptext, ZEROIZE ? '0 : p);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", 128'(bus_if.resp_valid), 128'(1));
            check("hold_ctext", bus_if.resp_ctext, c);
            check("hold_id", 128'(bus_if.resp_id), 128'(exp_id));
            check("hold_req_ready", 128'(bus_if.req_ready), 128'(0));
        end
        bus_if.resp_ready = 1'b1;
        tick();
        check("resp_done", 128'(bus_if.resp_valid), 128'(0));
        check("after_ctext", bus_if.resp_ctext, ZEROIZE ? '0 : c);
        check("after_id", 128'(bus_if.resp_id), ZEROIZE ? '0 : 128'(exp_id));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [4];
        int   acc;
        int   prev;
        int   h;
        int   m_last;
        int   exp_id;
        logic [NUM_REQ-1:0] mask;

        rst_n = 1'b0;
        bus_if.req_valid  = '0;
        bus_if.resp_ready = 1'b1;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            rp[ID_W'(i)] = '0;
            rk[ID_W'(i)] = '0;
        end

        vecs[0] = '{0, FIPS_P, FIPS_K, FIPS_C, 0};
        vecs[1] = '{3, 128'h0, 128'h0, ZERO_C, 3};
        vecs[2] = '{2, 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 128'h0, 2};
        vecs[2].ctext = core_fn(vecs[2].ptext, vecs[2].key);
        vecs[3] = '{1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 128'h0, 1};
        vecs[3].ctext = core_fn(vecs[3].ptext, vecs[3].key);

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check_reset_vals();

        // Table: single requester per vector, other ports carry unrelated data
        for (int i = 0; i < 4; i++) begin
            rand_ports();
            rp[ID_W'(vecs[i].port)] = vecs[i].ptext;
            rk[ID_W'(vecs[i].port)] = vecs[i].key;
            wait_accept(onehot(vecs[i].port), vecs[i].id, acc);
            bus_if.req_valid = '0;
            wait_resp(vecs[i].id, vecs[i].ptext, vecs[i].key, vecs[i].ctext, acc, 0);
        end

        // Fairness: all four requesting continuously from reset
        do_reset();
        rand_ports();
        prev = 0;
        for (int k = 0; k < 8; k++) begin
            exp_id = k % int'(NUM_REQ);
            wait_accept('1, exp_id, acc);
            if (k > 0) check("accept_spacing", 128'(acc - prev), 128'(CORE_LAT + 2));
            prev = acc;
            wait_resp(exp_id, rp[ID_W'(exp_id)], rk[ID_W'(exp_id)],
                      core_fn(rp[ID_W'(exp_id)], rk[ID_W'(exp_id)]), acc, 0);
        end

        // Backpressure: response held 10 cycles while requester 1 waits
        rand_ports();
        wait_accept(4'b0001, 0, acc);
        bus_if.req_valid = 4'b0010;
        wait_resp(0, rp[0], rk[0], core_fn(rp[0], rk[0]), acc, 10);
        h = cyc;
        wait_accept(4'b0010, 1, acc);
        check("grant_after_handshake", 128'(acc - h), 128'(1));
        bus_if.req_valid = '0;
        wait_resp(1, rp[1], rk[1], core_fn(rp[1], rk[1]), acc, 0);

        // Reset one cycle after accept aborts the operation
        rand_ports();
        wait_accept(4'b0100, 2, acc);
        bus_if.req_valid = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_vals();
        for (int i = 0; i < 6; i++) begin
            tick();
            check("no_stale_valid", 128'(bus_if.resp_valid), 128'(0));
        end
        wait_accept(4'b1001, 0, acc);
        bus_if.req_valid = '0;
        wait_resp(0, rp[0], rk[0], core_fn(rp[0], rk[0]), acc, 0);

        // Random traffic against the round-robin model
        do_reset();
        m_last = int'(NUM_REQ) - 1;
        for (int op = 0; op < 60; op++) begin
            rand_ports();
            mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            exp_id = rr_pick(mask, m_last);
            wait_accept(mask, exp_id, acc);
            bus_if.req_valid = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
            wait_resp(exp_id, rp[ID_W'(exp_id)], rk[ID_W'(exp_id)],
                      core_fn(rp[ID_W'(exp_id)], rk[ID_W'(exp_id)]), acc, int'($urandom_range(0, 3)));
            m_last = exp_id;
            if ($urandom_range(0, 3) == 0) begin
                bus_if.req_valid = '0;
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
